// File: rtl/sha256_nonce_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha256_nonce_sweeper: walks a nonce range through simplified_sha256 and  |
// | stops on the first hash strictly below a 256-bit target. Rev 1.0         |
// +--------------------------------------------------------------------------+
module sha256_nonce_sweeper #(
  parameter int NUM_OF_WORDS = 20,
  parameter int NONCE_WORD   = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  message_addr,
  input  logic [15:0]  output_addr,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_count,
  input  logic [255:0] target,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [31:0]  nonces_tried,
  output logic         hash_start,
  input  logic         hash_done,
  output logic         mem_owner,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  output logic [31:0]  mem_write_data,
  input  logic [31:0]  mem_read_data
);

  // The offset is folded into the message so a bad parameter cannot address past it.
  localparam logic [15:0] NONCE_OFS = 16'(NONCE_WORD % NUM_OF_WORDS);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR_NONCE  = 4'd1;
  localparam logic [3:0] S_KICK      = 4'd2;
  localparam logic [3:0] S_WAIT_BUSY = 4'd3;
  localparam logic [3:0] S_WAIT_DONE = 4'd4;
  localparam logic [3:0] S_RD_ADDR   = 4'd5;
  localparam logic [3:0] S_RD_WAIT   = 4'd6;
  localparam logic [3:0] S_RD_CMP    = 4'd7;
  localparam logic [3:0] S_EVAL      = 4'd8;
  localparam logic [3:0] S_FINISH    = 4'd9;

  logic [3:0]   state_q, state_d;
  logic         busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic [31:0]  found_nonce_q, found_nonce_d, nonces_tried_q, nonces_tried_d;
  logic         hash_start_q, hash_start_d, mem_owner_q, mem_owner_d, mem_we_q, mem_we_d;
  logic [15:0]  mem_addr_q, mem_addr_d;
  logic [31:0]  mem_write_data_q, mem_write_data_d;
  logic [31:0]  cur_q, cur_d, rem_q, rem_d;
  logic [255:0] tgt_q, tgt_d;
  logic [15:0]  nonce_addr_q, nonce_addr_d, out_addr_q, out_addr_d;
  logic [2:0]   idx_q, idx_d;
  logic         decided_q, decided_d, lt_q, lt_d;
  logic [31:0]  tgt_word;

  assign tgt_word = tgt_q[{3'd7 - idx_q, 5'd0} +: 32];

  always_comb begin
    state_d          = state_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    found_d          = found_q;
    found_nonce_d    = found_nonce_q;
    nonces_tried_d   = nonces_tried_q;
    hash_start_d     = 1'b0;
    mem_owner_d      = mem_owner_q;
    mem_we_d         = 1'b0;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    cur_d            = cur_q;
    rem_d            = rem_q;
    tgt_d            = tgt_q;
    nonce_addr_d     = nonce_addr_q;
    out_addr_d       = out_addr_q;
    idx_d            = idx_q;
    decided_d        = decided_q;
    lt_d             = lt_q;
    case (state_q)
      S_IDLE: begin
        // busy_q is still high in the cycle done is visible, so that start is not taken
        busy_d = 1'b0;
        if (start && !busy_q) begin
          busy_d         = 1'b1;
          found_d        = 1'b0;
          found_nonce_d  = 32'd0;
          nonces_tried_d = 32'd0;
          cur_d          = nonce_start;
          rem_d          = nonce_count;
          tgt_d          = target;
          nonce_addr_d   = message_addr + NONCE_OFS;
          out_addr_d     = output_addr;
          state_d        = (nonce_count == 32'd0) ? S_FINISH : S_WR_NONCE;
        end
      end
      S_WR_NONCE: begin
        mem_we_d         = 1'b1;
        mem_addr_d       = nonce_addr_q;
        mem_write_data_d = cur_q;
        state_d          = S_KICK;
      end
      S_KICK: begin
        hash_start_d = 1'b1;
        mem_owner_d  = 1'b1;
        state_d      = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!hash_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (hash_done) begin
          mem_owner_d = 1'b0;
          idx_d       = 3'd0;
          decided_d   = 1'b0;
          lt_d        = 1'b0;
          state_d     = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        mem_addr_d = out_addr_q + {13'd0, idx_q};
        state_d    = S_RD_WAIT;
      end
      S_RD_WAIT: state_d = S_RD_CMP;
      S_RD_CMP: begin
        if (!decided_q && (mem_read_data != tgt_word)) begin
          decided_d = 1'b1;
          lt_d      = (mem_read_data < tgt_word);
        end
        if (idx_q == 3'd7) begin
          state_d = S_EVAL;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_RD_ADDR;
        end
      end
      S_EVAL: begin
        nonces_tried_d = nonces_tried_q + 32'd1;
        if (lt_q) begin
          found_d       = 1'b1;
          found_nonce_d = cur_q;
          state_d       = S_FINISH;
        end else begin
          rem_d = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            state_d = S_FINISH;
          end else begin
            cur_d   = cur_q + 32'd1;
            state_d = S_WR_NONCE;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      found_q          <= 1'b0;
      found_nonce_q    <= 32'd0;
      nonces_tried_q   <= 32'd0;
      hash_start_q     <= 1'b0;
      mem_owner_q      <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= 16'd0;
      mem_write_data_q <= 32'd0;
      cur_q            <= 32'd0;
      rem_q            <= 32'd0;
      tgt_q            <= 256'd0;
      nonce_addr_q     <= 16'd0;
      out_addr_q       <= 16'd0;
      idx_q            <= 3'd0;
      decided_q        <= 1'b0;
      lt_q             <= 1'b0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      found_q          <= found_d;
      found_nonce_q    <= found_nonce_d;
      nonces_tried_q   <= nonces_tried_d;
      hash_start_q     <= hash_start_d;
      mem_owner_q      <= mem_owner_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      cur_q            <= cur_d;
      rem_q            <= rem_d;
      tgt_q            <= tgt_d;
      nonce_addr_q     <= nonce_addr_d;
      out_addr_q       <= out_addr_d;
      idx_q            <= idx_d;
      decided_q        <= decided_d;
      lt_q             <= lt_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign found          = found_q;
  assign found_nonce    = found_nonce_q;
  assign nonces_tried   = nonces_tried_q;
  assign hash_start     = hash_start_q;
  assign mem_owner      = mem_owner_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_nonce_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sha256_nonce_sweeper: sweeper against a memory + fake-hasher model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sha256_nonce_sweeper;

  localparam logic [31:0] SALT = 32'hC0FFEE11;

  typedef struct {
    logic [15:0]  ma;
    logic [15:0]  oa;
    logic [31:0]  ns;
    logic [31:0]  cnt;
    logic [255:0] tgt;
    logic         ef;
    logic [31:0]  en;
    logic [31:0]  et;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  message_addr = '0;
  logic [15:0]  output_addr = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_count = '0;
  logic [255:0] target = '0;
  logic         busy, done, found, hash_start, mem_owner, mem_we;
  logic [31:0]  found_nonce, nonces_tried, mem_write_data;
  logic [15:0]  mem_addr;
  logic         hash_done = 1'b1;
  logic [31:0]  mem_read_data = '0;

  int errors = 0;
  int checks = 0;

  // Environment state, all written only by the model process below
  logic [31:0] mem [0:65535];
  int          hb_cnt = 0;
  int          hs_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          viol = 0;
  logic [15:0] wr_addr [0:4095];
  logic [31:0] wr_data [0:4095];

  // Written only by the stimulus process
  logic [15:0] cur_ma = '0;
  logic [15:0] cur_oa = '0;
  int          lat_fixed = 0;

  sha256_nonce_sweeper #(.NUM_OF_WORDS(20), .NONCE_WORD(19)) dut (
    .clk(clk), .reset(reset), .start(start),
    .message_addr(message_addr), .output_addr(output_addr),
    .nonce_start(nonce_start), .nonce_count(nonce_count), .target(target),
    .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
    .nonces_tried(nonces_tried), .hash_start(hash_start), .hash_done(hash_done),
    .mem_owner(mem_owner), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] hfun(input logic [31:0] n);
    logic [255:0] r;
    logic [31:0]  w;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      w = (n * 32'h9E3779B1) ^ (32'(i) * 32'h7F4A7C15) ^ SALT;
      w = w ^ (w >> 15);
      r[255 - 32*i -: 32] = w;
    end
    return r;
  endfunction

  // Synchronous memory, fake hasher and bus monitors
  always @(posedge clk) begin
    logic [255:0] hv;
    if (mem_we) begin
      mem[mem_addr] <= mem_write_data;
      wr_addr[wr_cnt % 4096] <= mem_addr;
      wr_data[wr_cnt % 4096] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    mem_read_data <= mem[mem_addr];
    if (hash_start) hs_cnt <= hs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (busy && ((mem_owner && mem_we) || (hb_cnt != 0 && !mem_owner))) viol <= viol + 1;
    if (hb_cnt != 0) begin
      hb_cnt <= hb_cnt - 1;
      if (hb_cnt == 1) begin
        hv = hfun(mem[16'(cur_ma + 16'd19)]);
        for (int i = 0; i < 8; i++) mem[16'(cur_oa + 16'(i))] <= hv[255 - 32*i -: 32];
        hash_done <= 1'b1;
      end
    end else if (hash_start) begin
      hb_cnt    <= (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 6));
      hash_done <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference: try nonces in order, stop on first hash strictly below target
  task automatic model(inout vec_t v);
    logic [31:0] n;
    v.ef = 1'b0; v.en = '0; v.et = '0;
    for (longint i = 0; i < longint'(v.cnt); i++) begin
      n = v.ns + 32'(i);
      v.et = v.et + 32'd1;
      if (hfun(n) < v.tgt) begin
        v.ef = 1'b1;
        v.en = n;
        break;
      end
    end
  endtask

  task automatic run_sweep(input vec_t v);
    int hs0, wr0, dn0, cyc, bound, bad, nw;
    bit seen;
    hs0 = hs_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    bound = int'(v.cnt) * 60 + 20;
    @(negedge clk);
    cur_ma = v.ma; cur_oa = v.oa;
    message_addr = v.ma; output_addr = v.oa;
    nonce_start = v.ns; nonce_count = v.cnt; target = v.tgt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    message_addr = 16'($urandom); output_addr = 16'($urandom);
    nonce_start = $urandom; nonce_count = $urandom; target = rnd256();
    seen = 0;
    while (!seen && cyc < bound) begin
      start = (cyc == 3 && v.cnt != 0);
      if (done) seen = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    if (v.cnt == 0) chk("zero_count_latency", 64'(cyc), 64'd2);
    chk("busy_at_done", 64'(busy), 64'd1);
    chk("found", 64'(found), 64'(v.ef));
    chk("found_nonce", 64'(found_nonce), 64'(v.en));
    chk("nonces_tried", 64'(nonces_tried), 64'(v.et));
    chk("hash_start_pulses", 64'(hs_cnt - hs0), 64'(v.et));
    nw = wr_cnt - wr0;
    chk("nonce_writes", 64'(nw), 64'(v.et));
    bad = 0;
    for (int i = 0; i < nw; i++) begin
      if (wr_addr[(wr0 + i) % 4096] !== 16'(v.ma + 16'd19)) bad++;
      if (wr_data[(wr0 + i) % 4096] !== v.ns + 32'(i)) bad++;
    end
    chk("write_seq", 64'(bad), 64'd0);
    @(negedge clk);
    chk("busy_drop", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("done_pulses", 64'(done_cnt - dn0), 64'd1);
    chk("bus_ownership", 64'(viol), 64'd0);
  endtask

  initial begin
    vec_t tbl [7];
    vec_t v;
    int   k, mode, hs0, dn0, cyc;
    logic [255:0] base;

    tbl[0] = '{ma:16'h0000, oa:16'h0100, ns:32'h12345678, cnt:32'd1, tgt:'0, ef:1'b0, en:32'd0, et:32'd1};
    tbl[1] = '{ma:16'h0010, oa:16'h0200, ns:32'd5, cnt:32'd10, tgt:{256{1'b1}}, ef:1'b1, en:32'd5, et:32'd1};
    tbl[2] = '{ma:16'h0020, oa:16'h0300, ns:32'd5, cnt:32'd3, tgt:'0, ef:1'b0, en:32'd0, et:32'd3};
    tbl[3] = '{ma:16'h0030, oa:16'h0400, ns:32'd9, cnt:32'd0, tgt:{256{1'b1}}, ef:1'b0, en:32'd0, et:32'd0};
    tbl[4] = '{ma:16'hFFF0, oa:16'hFFFC, ns:32'hFFFFFFFF, cnt:32'd2, tgt:'0, ef:1'b0, en:32'd0, et:32'd2};
    tbl[5] = '{ma:16'h0040, oa:16'h0500, ns:32'd5, cnt:32'd1, tgt:hfun(32'd5), ef:1'b0, en:32'd0, et:32'd1};
    tbl[6] = '{ma:16'h0050, oa:16'h0600, ns:32'd5, cnt:32'd1, tgt:hfun(32'd5) + 256'd1, ef:1'b1, en:32'd5, et:32'd1};

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_bus", 64'({hash_start, mem_owner, mem_we, found, mem_addr, mem_write_data}), 64'd0);
    chk("reset_counters", {found_nonce, nonces_tried}, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_sweep(tbl[i]);

    for (int r = 0; r < 24; r++) begin
      v.ma  = 16'($urandom);
      v.oa  = v.ma + 16'd40;
      v.cnt = $urandom_range(1, 8);
      v.ns  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
      k     = $urandom_range(0, int'(v.cnt) - 1);
      base  = hfun(v.ns + 32'(k));
      mode  = $urandom_range(0, 4);
      case (mode)
        0: v.tgt = base;
        1: v.tgt = base + 256'd1;
        2: v.tgt = base - 256'd1;
        3: v.tgt = rnd256();
        default: v.tgt = {base[255:224], rnd256() >> 32};
      endcase
      model(v);
      run_sweep(v);
    end

    // Abort in the middle of the second hash, then sweep again cleanly
    lat_fixed = 30;
    hs0 = hs_cnt; dn0 = done_cnt;
    @(negedge clk);
    cur_ma = 16'h0100; cur_oa = 16'h0200;
    message_addr = 16'h0100; output_addr = 16'h0200;
    nonce_start = 32'd100; nonce_count = 32'd3; target = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!((hs_cnt - hs0) == 2 && hash_done == 1'b0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_wait_done", 64'(cyc < 400), 64'd1);
    @(negedge clk);
    chk("tried_before_abort", 64'(nonces_tried), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_bus", 64'({hash_start, mem_owner, mem_we, done, mem_addr}), 64'd0);
    chk("abort_counters", {found_nonce, nonces_tried}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    while (hb_cnt != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("hasher_idle", 64'(hb_cnt), 64'd0);
    lat_fixed = 0;
    repeat (3) @(negedge clk);
    chk("no_done_after_abort", 64'(done_cnt - dn0), 64'd0);
    v = '{ma:16'h0300, oa:16'h0400, ns:32'd200, cnt:32'd4, tgt:hfun(32'd202) + 256'd1, ef:1'b0, en:32'd0, et:32'd0};
    model(v);
    run_sweep(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
